// File: rtl/step_dir_filter_if.sv
// Signal bundle for step_dir_filter: raw step/dir pins, control strobes
// and the qualified step/direction/position outputs.
// master = the side that drives the pins (controller or bench),
// slave  = the filter block itself.
interface step_dir_filter_if #(
   parameter int POS_W = 32
) ();
   logic             step_in;
   logic             dir_in;
   logic             enable;
   logic             invert_dir;
   logic             clear_pos;
   logic             clr_err;
   logic             step_pulse;
   logic             step_dir;
   logic [POS_W-1:0] position;
   logic             dir_err;

   modport master (
      output step_in, dir_in, enable, invert_dir, clear_pos, clr_err,
      input  step_pulse, step_dir, position, dir_err
   );

   modport slave (
      input  step_in, dir_in, enable, invert_dir, clear_pos, clr_err,
      output step_pulse, step_dir, position, dir_err
   );
endinterface

// File: rtl/step_dir_filter.sv
// step_dir_filter: synchronizes and glitch-filters a raw STEP/DIR pin pair,
// emits a one-cycle step strobe with its qualified direction, flags
// direction-setup violations and optionally tracks a signed position.
// Optional feature macro: STEP_DIR_FILTER_POSITION_EN enables the position
// counter and clear_pos; without it position is tied to zero.
module step_dir_filter #(
   parameter int FILTER_LEN = 4,
   parameter int DIR_SETUP  = 2,
   parameter int POS_W      = 32
) (
   input logic               clk,
   input logic               resetn,
   step_dir_filter_if.slave  bus
);

   localparam logic [7:0] FL_LAST = 8'(FILTER_LEN - 1);
   localparam logic [7:0] DS_SAT  = 8'(DIR_SETUP);

   logic       r_step_s1, r_step_s2, r_dir_s1, r_dir_s2;
   logic       r_step_f, r_step_f_d, r_dir_f;
   logic [7:0] r_step_cnt, r_dir_cnt, r_since;
   logic       r_step_pulse, r_step_dir, r_dir_err;

   logic       w_step_toggle, w_dir_toggle, w_step_rise;
   logic       w_issue, w_viol;

   // The filtered level flips on the cycle its counter would reach FILTER_LEN.
   assign w_step_toggle = (r_step_s2 != r_step_f) && (r_step_cnt == FL_LAST);
   assign w_dir_toggle  = (r_dir_s2 != r_dir_f) && (r_dir_cnt == FL_LAST);
   assign w_step_rise   = r_step_f & ~r_step_f_d;
   // Edges seen while disabled are dropped, never queued.
   assign w_issue       = w_step_rise & bus.enable;
   assign w_viol        = w_issue & (r_since < DS_SAT);

   // Two-flop synchronizers for both raw pins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_step_s1 <= 1'b0;
         r_step_s2 <= 1'b0;
         r_dir_s1  <= 1'b0;
         r_dir_s2  <= 1'b0;
      end else begin
         r_step_s1 <= bus.step_in;
         r_step_s2 <= r_step_s1;
         r_dir_s1  <= bus.dir_in;
         r_dir_s2  <= r_dir_s1;
      end
   end

   // Step glitch filter: count disagreeing cycles, flip level on the FILTER_LEN-th.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_step_f   <= 1'b0;
         r_step_cnt <= 8'd0;
      end else if (r_step_s2 != r_step_f) begin
         if (w_step_toggle) begin
            r_step_f   <= ~r_step_f;
            r_step_cnt <= 8'd0;
         end else begin
            r_step_cnt <= r_step_cnt + 8'd1;
         end
      end else begin
         r_step_cnt <= 8'd0;
      end
   end

   // Direction glitch filter, same rule as the step filter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dir_f   <= 1'b0;
         r_dir_cnt <= 8'd0;
      end else if (r_dir_s2 != r_dir_f) begin
         if (w_dir_toggle) begin
            r_dir_f   <= ~r_dir_f;
            r_dir_cnt <= 8'd0;
         end else begin
            r_dir_cnt <= r_dir_cnt + 8'd1;
         end
      end else begin
         r_dir_cnt <= 8'd0;
      end
   end

   // Delayed filtered step level for rising-edge detection.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_step_f_d <= 1'b0;
      end else begin
         r_step_f_d <= r_step_f;
      end
   end

   // Cycles since the last accepted direction change, saturating at DIR_SETUP.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_since <= DS_SAT;
      end else if (w_dir_toggle) begin
         r_since <= 8'd0;
      end else if (r_since < DS_SAT) begin
         r_since <= r_since + 8'd1;
      end else begin
         r_since <= r_since;
      end
   end

   // Step strobe and its direction, captured at the accepted step edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_step_pulse <= 1'b0;
         r_step_dir   <= 1'b0;
      end else begin
         r_step_pulse <= w_issue;
         if (w_issue) begin
            r_step_dir <= r_dir_f ^ bus.invert_dir;
         end else begin
            r_step_dir <= r_step_dir;
         end
      end
   end

   // Sticky setup-violation flag; a new violation beats a same-cycle clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dir_err <= 1'b0;
      end else if (w_viol) begin
         r_dir_err <= 1'b1;
      end else if (bus.clr_err) begin
         r_dir_err <= 1'b0;
      end else begin
         r_dir_err <= r_dir_err;
      end
   end

   assign bus.step_pulse = r_step_pulse;
   assign bus.step_dir   = r_step_dir;
   assign bus.dir_err    = r_dir_err;

`ifdef STEP_DIR_FILTER_POSITION_EN
   logic [POS_W-1:0] r_position;

   // Signed position: clear wins over a same-cycle step, wraps freely.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_position <= {POS_W{1'b0}};
      end else if (bus.clear_pos) begin
         r_position <= {POS_W{1'b0}};
      end else if (r_step_pulse) begin
         if (r_step_dir) begin
            r_position <= r_position + {{(POS_W-1){1'b0}}, 1'b1};
         end else begin
            r_position <= r_position - {{(POS_W-1){1'b0}}, 1'b1};
         end
      end else begin
         r_position <= r_position;
      end
   end

   assign bus.position = r_position;
`else
   logic w_unused_clear_pos;

   assign w_unused_clear_pos = bus.clear_pos;
   assign bus.position       = {POS_W{1'b0}};
`endif

endmodule

// File: tb/tb_step_dir_filter.sv
// Self-checking bench for step_dir_filter: directed scenarios plus a random
// phase, all compared against a window-based behavioural model.
module tb_step_dir_filter;

   localparam int FL     = 4;
   localparam int DS     = 2;
   localparam int PW     = 8;   // narrow counter so wrap-around is reachable
   localparam int RB     = 64;

   logic clk;
   logic resetn;

   step_dir_filter_if #(.POS_W(PW)) bus ();

   step_dir_filter #(
      .FILTER_LEN (FL),
      .DIR_SETUP  (DS),
      .POS_W      (PW)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;
   int obs_pulses;

   // model state
   bit          m_sx [RB];
   bit          m_dx [RB];
   int          m_n;
   int          m_last_chg;
   bit          m_step_f, m_dir_f, m_rise;
   bit          m_pulse, m_sdir, m_err;
   logic [PW-1:0] m_pos;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n        = 0;
      m_last_chg = -1000;
      m_step_f   = 1'b0;
      m_dir_f    = 1'b0;
      m_rise     = 1'b0;
      m_pulse    = 1'b0;
      m_sdir     = 1'b0;
      m_err      = 1'b0;
      m_pos      = '0;
   endtask

   // Pin value sampled at edge idx; nothing before reset release counts.
   function automatic bit hist(input bit sel_dir, input int idx);
      if (idx < 1) return 1'b0;
      return sel_dir ? m_dx[idx % RB] : m_sx[idx % RB];
   endfunction

   // A new level is accepted when the FL synchronized samples feeding this
   // edge (pin samples 2..FL+1 edges back) all disagree with the held level.
   function automatic bit all_differ(input bit sel_dir, input int n, input bit lvl);
      for (int k = 2; k <= FL + 1; k++) begin
         if (hist(sel_dir, n - k) == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_edge();
      bit issue, viol, old_f;
      m_n++;
      m_sx[m_n % RB] = bus.step_in;
      m_dx[m_n % RB] = bus.dir_in;
      issue = m_rise & bus.enable;
      viol  = issue && ((m_n - 1 - m_last_chg) < DS);
`ifdef STEP_DIR_FILTER_POSITION_EN
      if (bus.clear_pos) m_pos = '0;
      else if (m_pulse)  m_pos = m_sdir ? m_pos + 1'b1 : m_pos - 1'b1;
`endif
      if (viol)             m_err = 1'b1;
      else if (bus.clr_err) m_err = 1'b0;
      if (issue) m_sdir = m_dir_f ^ bus.invert_dir;
      m_pulse = issue;
      old_f = m_step_f;
      if (all_differ(1'b0, m_n, m_step_f)) m_step_f = ~m_step_f;
      m_rise = m_step_f & ~old_f;
      if (all_differ(1'b1, m_n, m_dir_f)) begin
         m_dir_f    = ~m_dir_f;
         m_last_chg = m_n;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (bus.step_pulse === 1'b1) obs_pulses++;
      check_val("step_pulse", bus.step_pulse, m_pulse);
      check_val("step_dir",   bus.step_dir,   m_sdir);
      check_val("dir_err",    bus.dir_err,    m_err);
      check_val("position",   bus.position,   m_pos);
   endtask

   task automatic apply_reset(input int cycles);
      resetn = 1'b0;
      model_reset();
      #1;
      check_val("rst_pulse", bus.step_pulse, 1'b0);
      check_val("rst_dir",   bus.step_dir,   1'b0);
      check_val("rst_err",   bus.dir_err,    1'b0);
      check_val("rst_pos",   bus.position,   '0);
      repeat (cycles) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic step_once();
      bus.step_in = 1'b1;
      repeat (6) tick();
      bus.step_in = 1'b0;
      repeat (6) tick();
   endtask

   // Raise step_in and watch a bounded window for the first strobe.
   task automatic run_rise(input int window, output int first, output int count);
      first = -1;
      count = 0;
      bus.step_in = 1'b1;
      for (int i = 1; i <= window; i++) begin
         tick();
         if (bus.step_pulse === 1'b1) begin
            count++;
            if (first < 0) first = i;
         end
      end
   endtask

   initial begin
      int first, cnt, p0, sh, dh, seen;
      n_checks   = 0;
      n_errors   = 0;
      obs_pulses = 0;
      resetn         = 1'b0;
      bus.step_in    = 1'b0;
      bus.dir_in     = 1'b1;
      bus.enable     = 1'b1;
      bus.invert_dir = 1'b0;
      bus.clear_pos  = 1'b0;
      bus.clr_err    = 1'b0;
      @(negedge clk);
      apply_reset(3);
      repeat (20) tick();

      // forward step latency from a clean rise
      run_rise(12, first, cnt);
      check_val("latency", first, 7);
      check_val("one_pulse", cnt, 1);
      check_val("fwd_dir", bus.step_dir, 1'b1);
`ifdef STEP_DIR_FILTER_POSITION_EN
      check_val("fwd_pos", bus.position, 8'd1);
`else
      check_val("fwd_pos", bus.position, 8'd0);
`endif
      bus.step_in = 1'b0;
      repeat (10) tick();

      // 3-cycle glitch is rejected
      p0 = obs_pulses;
      bus.step_in = 1'b1;
      repeat (3) tick();
      bus.step_in = 1'b0;
      repeat (12) tick();
      check_val("glitch_pulses", obs_pulses - p0, 0);

      // dir change one cycle before the step edge
      bus.dir_in = 1'b0;
      tick();
      run_rise(12, first, cnt);
      check_val("setup_err", bus.dir_err, 1'b1);
      check_val("setup_dir", bus.step_dir, 1'b0);
      check_val("setup_pos", bus.position, 8'd0);
      bus.step_in = 1'b0;
      repeat (8) tick();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      check_val("err_cleared", bus.dir_err, 1'b0);
      bus.dir_in = 1'b1;
      repeat (10) tick();

      // clear_pos during the strobe cycle wins
      step_once();
      bus.step_in = 1'b1;
      seen = 0;
      for (int i = 0; i < 15 && seen == 0; i++) begin
         tick();
         if (bus.step_pulse === 1'b1) seen = 1;
      end
      check_val("clr_seen_pulse", seen, 1);
      bus.clear_pos = 1'b1;
      tick();
      bus.clear_pos = 1'b0;
      check_val("clr_pos", bus.position, 8'd0);
      bus.step_in = 1'b0;
      repeat (8) tick();

      // disabled: ten steps discarded
      p0 = obs_pulses;
      bus.enable = 1'b0;
      repeat (10) step_once();
      bus.enable = 1'b1;
      repeat (4) tick();
      check_val("dis_pulses", obs_pulses - p0, 0);
      check_val("dis_pos", bus.position, 8'd0);

      // five enabled steps
      p0 = obs_pulses;
      repeat (5) step_once();
      check_val("five_pulses", obs_pulses - p0, 5);
`ifdef STEP_DIR_FILTER_POSITION_EN
      check_val("five_pos", bus.position, 8'd5);
      // two's-complement wrap in both directions
      bus.clear_pos = 1'b1;
      tick();
      bus.clear_pos = 1'b0;
      repeat (127) step_once();
      check_val("pos_max", bus.position, 8'h7F);
      step_once();
      check_val("wrap_fwd", bus.position, 8'h80);
      bus.invert_dir = 1'b1;
      step_once();
      check_val("wrap_rev", bus.position, 8'h7F);
      check_val("inv_dir", bus.step_dir, 1'b0);
      bus.invert_dir = 1'b0;
`else
      check_val("five_pos", bus.position, 8'd0);
`endif

      // random pin activity against the model
      sh = 1;
      dh = 1;
      for (int i = 0; i < 3000; i++) begin
         if (--sh == 0) begin
            bus.step_in = ~bus.step_in;
            sh = $urandom_range(1, 8);
         end
         if (--dh == 0) begin
            bus.dir_in = ~bus.dir_in;
            dh = $urandom_range(1, 14);
         end
         bus.enable     = ($urandom_range(0, 7) != 0);
         bus.clr_err    = ($urandom_range(0, 9) == 0);
         bus.clear_pos  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) bus.invert_dir = ~bus.invert_dir;
         tick();
      end
      bus.enable    = 1'b1;
      bus.clr_err   = 1'b0;
      bus.clear_pos = 1'b0;
      bus.step_in   = 1'b0;
      repeat (12) tick();

      // reset mid-filter with step_in held high: exactly one strobe after release
      bus.step_in = 1'b1;
      repeat (2) tick();
      apply_reset(2);
      run_rise(14, first, cnt);
      check_val("rst_latency", first, 7);
      check_val("rst_one_pulse", cnt, 1);
      bus.step_in = 1'b0;
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
